// File: rtl/phase_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : phase_frame_deserializer
// Brief    : Serial-to-parallel front end for the ONN phase path. Hunts for
//            SYNC_PAT, shifts in N_PHASE words of PHASE_W bits (MSB first)
//            and publishes the packed frame over a valid/ready handshake.
//            Optional macro PHASE_FRAME_PARITY_EN adds a trailing even-parity
//            bit per frame; a failing frame is dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module phase_frame_deserializer #(
    parameter int                  PHASE_W  = 4,
    parameter int                  N_PHASE  = 15,
    parameter int                  SYNC_LEN = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 8'b1111_0000,
    parameter int                  CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_en,
    input  logic                          phi_ready,
    input  logic                          clr_err,
    output logic [0:N_PHASE*PHASE_W-1]    phi_out,
    output logic                          phi_valid,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          busy,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int                FRAME_BITS = N_PHASE * PHASE_W;
    localparam int                BC_W       = $clog2(FRAME_BITS);
    localparam logic [BC_W-1:0]   LAST_BIT   = BC_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_RECV = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_LEN-1:0]     sync_sr;
    logic [BC_W-1:0]         bit_cnt;
    logic [0:FRAME_BITS-1]   payload;

    logic [SYNC_LEN-1:0]     w_sync_next;
    logic [0:FRAME_BITS-1]   w_shift;
    logic [0:FRAME_BITS-1]   w_frame;
    logic                    w_done;
    logic                    w_can_load;

    // Next values of the shifters: sync enters at the LSB, payload fills
    // toward the high index so the first payload bit ends up at index 0.
    assign w_sync_next = {sync_sr[SYNC_LEN-2:0], bit_in};
    assign w_shift     = {payload[1:FRAME_BITS-1], bit_in};
    assign w_can_load  = !phi_valid || phi_ready;

`ifdef PHASE_FRAME_PARITY_EN
    logic w_par_ok;
    logic perr_r;

    // Frame completes on the parity bit; even parity over the stored payload.
    assign w_par_ok   = (bit_in == ^payload);
    assign w_done     = bit_en && (state == S_PAR) && w_par_ok;
    assign w_frame    = payload;
    assign parity_err = perr_r;
`else
    // Frame completes on the last payload bit; publish the shifted-in word.
    assign w_done     = bit_en && (state == S_RECV) && (bit_cnt == LAST_BIT);
    assign w_frame    = w_shift;
    assign parity_err = 1'b0;
`endif

    // Control FSM plus registered output/handshake/error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HUNT;
            sync_sr   <= '0;
            bit_cnt   <= '0;
            payload   <= '0;
            phi_out   <= '0;
            phi_valid <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef PHASE_FRAME_PARITY_EN
            perr_r    <= 1'b0;
`endif
        end else begin
            // Consumer accept; a publish below in the same cycle overrides.
            if (phi_valid && phi_ready) begin
                phi_valid <= 1'b0;
            end

            // Clear first so that a same-cycle set event takes priority.
            if (clr_err) begin
                overrun <= 1'b0;
`ifdef PHASE_FRAME_PARITY_EN
                perr_r  <= 1'b0;
`endif
            end

            if (w_done) begin
                if (w_can_load) begin
                    phi_out   <= w_frame;
                    phi_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end

            if (bit_en) begin
                case (state)
                    S_HUNT: begin
                        if (w_sync_next == SYNC_PAT) begin
                            state   <= S_RECV;
                            busy    <= 1'b1;
                            sync_sr <= '0;
                            bit_cnt <= '0;
                        end else begin
                            sync_sr <= w_sync_next;
                        end
                    end
                    S_RECV: begin
                        payload <= w_shift;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef PHASE_FRAME_PARITY_EN
                            state   <= S_PAR;
`else
                            state   <= S_HUNT;
                            busy    <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef PHASE_FRAME_PARITY_EN
                    S_PAR: begin
                        state <= S_HUNT;
                        busy  <= 1'b0;
                        if (!w_par_ok) begin
                            perr_r <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= S_HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_frame_deserializer
// Brief    : Self-checking bench for phase_frame_deserializer. A bit-level
//            reference model (history window, bit array, publish rules) is
//            compared against the DUT every cycle, plus literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_frame_deserializer;

    localparam int         FB   = 60;
    localparam logic [7:0] SYNC = 8'b1111_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_en = 1'b0;
    logic          phi_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [0:FB-1] phi_out;
    logic          phi_valid;
    logic [7:0]    frame_cnt;
    logic          busy;
    logic          overrun;
    logic          parity_err;

    int checks = 0;
    int errors = 0;

    phase_frame_deserializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .phi_ready  (phi_ready),
        .clr_err    (clr_err),
        .phi_out    (phi_out),
        .phi_valid  (phi_valid),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    m_hist  = '0;
    int            m_mode  = 0;   // 0 hunting, 1 collecting payload, 2 awaiting parity
    int            m_n     = 0;
    logic [0:FB-1] m_frame = '0;
    logic [0:FB-1] m_phi   = '0;
    logic          m_valid = 1'b0;
    logic          m_over  = 1'b0;
    logic          m_perr  = 1'b0;
    logic          m_busy  = 1'b0;
    logic [7:0]    m_cnt   = '0;

    task automatic model_step();
        logic done, set_over, set_perr, was_valid;
        if (!rst_n) begin
            m_hist = '0; m_mode = 0; m_n = 0; m_phi = '0; m_valid = 1'b0;
            m_over = 1'b0; m_perr = 1'b0; m_busy = 1'b0; m_cnt = '0;
            return;
        end
        done = 1'b0; set_over = 1'b0; set_perr = 1'b0; was_valid = m_valid;
        if (bit_en) begin
            if (m_mode == 0) begin
                m_hist = {m_hist[6:0], bit_in};
                if (m_hist == SYNC) begin
                    m_mode = 1; m_n = 0; m_hist = '0;
                end
            end else if (m_mode == 1) begin
                m_frame[m_n] = bit_in;
                m_n++;
                if (m_n == FB) begin
`ifdef PHASE_FRAME_PARITY_EN
                    m_mode = 2;
`else
                    m_mode = 0;
                    done = 1'b1;
`endif
                end
            end else begin
                m_mode = 0;
                if (bit_in == ^m_frame) done = 1'b1;
                else set_perr = 1'b1;
            end
        end
        if (was_valid && phi_ready) m_valid = 1'b0;
        if (done) begin
            if (!was_valid || phi_ready) begin
                m_phi = m_frame; m_valid = 1'b1; m_cnt = m_cnt + 8'd1;
            end else begin
                set_over = 1'b1;
            end
        end
        if (clr_err) begin m_over = 1'b0; m_perr = 1'b0; end
        if (set_over) m_over = 1'b1;
        if (set_perr) m_perr = 1'b1;
        m_busy = (m_mode != 0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("phi_out",    phi_out,    m_phi);
        chk("phi_valid",  phi_valid,  m_valid);
        chk("frame_cnt",  frame_cnt,  m_cnt);
        chk("busy",       busy,       m_busy);
        chk("overrun",    overrun,    m_over);
        chk("parity_err", parity_err, m_perr);
    end

    // ---------------- stimulus helpers ----------------
    logic stall_on = 1'b0;
    int   nb = 0;

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b; bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        if (stall_on && (nb % 4 == 3)) repeat (3) tick();
        nb++;
    endtask

    task automatic send_frame(input logic [59:0] p, input logic good_par, input logic ready_last);
        for (int i = 0; i < 8; i++) send_bit(SYNC[7-i]);
        for (int i = 0; i < FB; i++) begin
`ifndef PHASE_FRAME_PARITY_EN
            if (i == FB-1 && ready_last) phi_ready = 1'b1;
`endif
            send_bit(p[59-i]);
`ifndef PHASE_FRAME_PARITY_EN
            if (i == FB-1 && ready_last) phi_ready = 1'b0;
`endif
        end
`ifdef PHASE_FRAME_PARITY_EN
        if (ready_last) phi_ready = 1'b1;
        send_bit((^p) ^ !good_par);
        if (ready_last) phi_ready = 1'b0;
`else
        if (!good_par) chk("unused_par_arg", 64'(good_par), 64'(good_par));
`endif
    endtask

    task automatic pulse_ready();
        phi_ready = 1'b1; tick(); phi_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_wrap;
        repeat (2) tick();
        chk("reset_valid", 64'(phi_valid), 64'd0);
        chk("reset_cnt",   64'(frame_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, phases 0..E.
        send_frame(60'h0123456789ABCDE, 1'b1, 1'b0);
        chk("basic_phi",   64'(phi_out),   64'h0123456789ABCDE);
        chk("basic_valid", 64'(phi_valid), 64'd1);
        chk("basic_cnt",   64'(frame_cnt), 64'd1);
        chk("basic_ovr",   64'(overrun),   64'd0);
        chk("basic_busy",  64'(busy),      64'd0);

        // Overrun: second frame while first still pending.
        send_frame(60'hFFFFFFFFFFFFFFF, 1'b1, 1'b0);
        chk("ovr_phi", 64'(phi_out),   64'h0123456789ABCDE);
        chk("ovr_set", 64'(overrun),   64'd1);
        chk("ovr_cnt", 64'(frame_cnt), 64'd1);
        pulse_ready();
        chk("ovr_accept", 64'(phi_valid), 64'd0);
        pulse_clr();
        chk("ovr_clear", 64'(overrun), 64'd0);

        // Simultaneous accept and publish.
        send_frame(60'h555555555555555, 1'b1, 1'b0);
        chk("pre_sim_cnt", 64'(frame_cnt), 64'd2);
        send_frame(60'hAAAAAAAAAAAAAAA, 1'b1, 1'b1);
        chk("sim_valid", 64'(phi_valid), 64'd1);
        chk("sim_phi",   64'(phi_out),   64'hAAAAAAAAAAAAAAA);
        chk("sim_cnt",   64'(frame_cnt), 64'd3);
        chk("sim_ovr",   64'(overrun),   64'd0);

        // Stalls, partial sync plus noise, sync-like payload.
        pulse_ready();
        stall_on = 1'b1; nb = 0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        chk("no_false_lock", 64'(busy), 64'd0);
        send_frame(60'hF0F0F0F0F0F0F0F, 1'b1, 1'b0);
        stall_on = 1'b0;
        chk("stall_phi", 64'(phi_out),   64'hF0F0F0F0F0F0F0F);
        chk("stall_cnt", 64'(frame_cnt), 64'd4);

        // Reset mid-frame.
        pulse_ready();
        for (int i = 0; i < 8; i++) send_bit(SYNC[7-i]);
        for (int i = 0; i < 30; i++) send_bit(i[0]);
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_phi",   64'(phi_out),   64'd0);
        chk("rst_valid", 64'(phi_valid), 64'd0);
        chk("rst_cnt",   64'(frame_cnt), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(60'hFEDCBA987654321, 1'b1, 1'b0);
        chk("post_rst_phi", 64'(phi_out),   64'hFEDCBA987654321);
        chk("post_rst_cnt", 64'(frame_cnt), 64'd1);

`ifdef PHASE_FRAME_PARITY_EN
        send_frame(60'h111111111111111, 1'b0, 1'b0);
        chk("perr_set",   64'(parity_err), 64'd1);
        chk("perr_valid", 64'(phi_valid),  64'd1);
        chk("perr_cnt",   64'(frame_cnt),  64'd1);
        chk("perr_phi",   64'(phi_out),    64'hFEDCBA987654321);
        pulse_clr();
        chk("perr_clear", 64'(parity_err), 64'd0);
        send_frame(60'h111111111111111, 1'b1, 1'b1);
        chk("par_ok_phi", 64'(phi_out),   64'h111111111111111);
        chk("par_ok_cnt", 64'(frame_cnt), 64'd2);
        n_wrap = 254;
`else
        chk("perr_tied", 64'(parity_err), 64'd0);
        n_wrap = 255;
`endif

        // Counter wrap: stream frames with the consumer always ready.
        phi_ready = 1'b1;
        for (int i = 0; i < n_wrap; i++) send_frame(60'(i * 7 + 3), 1'b1, 1'b0);
        phi_ready = 1'b0;
        chk("wrap_cnt", 64'(frame_cnt), 64'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_frame_deserializer.md
Name: phase_frame_deserializer

Overview:
- Serial-to-parallel front end for the ONN phase path. Sits directly upstream of control_to_neuron.
- Hunts a serial bit stream for a sync pattern, then shifts in N_PHASE phase words of PHASE_W bits each, MSB first.
- Presents the packed phase vector phi_out with a valid/ready handshake, a frame counter and error flags.

Parameters:
- PHASE_W, 4, bits per oscillator phase word.
- N_PHASE, 15, phase words per frame (5x3 synapse matrix, row-major).
- SYNC_LEN, 8, sync pattern length in bits.
- SYNC_PAT, 8'b1111_0000, sync pattern, first-received bit in the MSB. Must not be all-zero.
- CNT_W, 8, frame counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit.
- bit_en  in  1  sample qualifier; bit_in is consumed only on clock edges where bit_en=1.
- phi_ready  in  1  consumer accepts phi_out.
- clr_err  in  1  synchronous clear of overrun and parity_err.
- phi_out  out  [0:N_PHASE*PHASE_W-1]  packed phases. Word k occupies bits [k*PHASE_W : k*PHASE_W+PHASE_W-1]; its lowest index is the word MSB.
- phi_valid  out  1  phi_out holds an unaccepted frame.
- frame_cnt  out  CNT_W  count of accepted (published) frames, wraps.
- busy  out  1  high in RECV/PAR states.
- overrun  out  1  sticky: a completed frame was dropped because phi_valid was still pending.
- parity_err  out  1  sticky parity failure (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT; all outputs 0 (phi_out=0, phi_valid=0, frame_cnt=0, busy=0, overrun=0, parity_err=0).
  - Sync shifter, bit counter and payload shifter = 0.
  - Reset mid-frame discards the partial frame.
- Bit mapping: FRAME_BITS = N_PHASE*PHASE_W (60). The first payload bit lands in phi_out[0]; the last lands in phi_out[FRAME_BITS-1].
- HUNT:
  - Each enabled bit shifts into the SYNC_LEN shifter (new bit enters at the LSB).
  - When the shifter value after the shift equals SYNC_PAT: go to RECV, clear bit count and sync shifter.
- RECV:
  - Each enabled bit shifts into the payload register and increments the bit count.
  - On the enabled edge that consumes payload bit FRAME_BITS-1: go to HUNT (or PAR if the feature is compiled in) and publish the frame.
- Publish (registered; result visible the cycle after the last-bit edge):
  - If phi_valid=0, or phi_valid=1 with phi_ready=1 in the same cycle: load phi_out, set phi_valid=1, increment frame_cnt.
  - Otherwise: keep the old phi_out, set overrun=1, leave frame_cnt unchanged.
- Handshake:
  - phi_valid falls on an edge where phi_valid=1 and phi_ready=1, unless a publish occurs in that same cycle (then it stays 1 with the new data).
  - phi_out is stable while phi_valid=1.
- bit_en=0 freezes the state, counters and shifters. Sync matching resumes after the frame without a gap.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- clr_err:
  - Clears overrun and parity_err next edge.
  - If a set event occurs in the same cycle, set wins.
- Sync-like bit patterns inside the payload are ignored (counted as payload).

Optional Feature:
- Macro: PHASE_FRAME_PARITY_EN.
- Defined:
  - After the payload, state PAR consumes one enabled bit: the even-parity bit over all FRAME_BITS payload bits.
  - Match: publish as described above.
  - Mismatch: no publish, phi_out/phi_valid/frame_cnt unchanged, parity_err=1 (sticky). Then return to HUNT.
- Undefined: no PAR state, frame publishes directly after the last payload bit, parity_err tied 0.

Test Plan:
- Reset then basic frame:
  - Stimulus: reset; bit_en=1; send 11110000, then phases 0x0..0xE MSB-first; phi_ready=0.
  - Response: one cycle after the 60th payload bit, phi_out=60'h0123456789ABCDE, phi_valid=1, frame_cnt=1, overrun=0.
- Overrun:
  - Stimulus: repeat the frame with phases all 0xF while phi_ready=0.
  - Response: phi_out unchanged (60'h0123456789ABCDE), overrun=1, frame_cnt=1. Then phi_ready=1 for one cycle → phi_valid=0. clr_err=1 → overrun=0.
- Simultaneous accept and publish:
  - Stimulus: phi_ready=1 exactly in the publish cycle of a new frame of all 0xA.
  - Response: phi_valid stays 1, phi_out=60'hAAAAAAAAAAAAAAA, frame_cnt increments, overrun=0.
- bit_en gaps and false sync:
  - Stimulus: insert bit_en=0 stalls of 3 cycles every 4 bits; precede the sync with 1111000 (7 bits) plus a noise 1.
  - Response: no false lock, correct phi_out once the full SYNC_PAT arrives.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 30 payload bits.
  - Response: all outputs 0 immediately; the next full frame decodes correctly.
- PHASE_FRAME_PARITY_EN defined:
  - Correct parity bit → publish.
  - Inverted parity bit → parity_err=1, phi_valid unchanged, frame_cnt unchanged.
